// File: rtl/simmem_write_resp_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : simmem_write_resp_bank                                     |
// | Description : Holding bank for AXI B-channel write responses. Responses  |
// |               are released only when their ID is enabled, oldest        |
// |               enabled response first (an age matrix keeps per-ID order). |
// |               write_resp_t layout: [8:1] = id, [0] = resp.               |
// |               Optional macro SIMMEM_WRITE_RESP_BANK_BYPASS_EN: an input  |
// |               arriving at an empty bank with its ID enabled is forwarded |
// |               combinationally to the output.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module simmem_write_resp_bank #(
   parameter int unsigned Capacity     = 32,
   parameter int unsigned SlotIdxWidth = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [8:0]              in_data_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [255:0]            release_en_i,
   output logic [8:0]              out_data_o,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [SlotIdxWidth:0]   free_slots_o
);

   localparam int unsigned          RESP_W    = 9;
   localparam logic [SlotIdxWidth:0] FREE_ONE = 1;
   localparam logic [SlotIdxWidth:0] FREE_ALL = (SlotIdxWidth+1)'(Capacity);

   // Slot storage and age matrix: older_q[i][j] set when slot i was written before slot j
   logic [Capacity-1:0]     valid_q, valid_d;
   logic [RESP_W-1:0]       data_q  [Capacity];
   logic [Capacity-1:0]     older_q [Capacity];
   logic                    locked_q, locked_d;
   logic [SlotIdxWidth-1:0] lock_idx_q, lock_idx_d;
   logic [SlotIdxWidth:0]   free_q, free_d;

   logic [Capacity-1:0]     w_cand;
   logic [Capacity-1:0]     w_sel_oh;
   logic [Capacity-1:0]     w_older_col [Capacity];
   logic [SlotIdxWidth-1:0] w_sel_idx;
   logic [SlotIdxWidth-1:0] w_wr_idx;
   logic [SlotIdxWidth-1:0] w_cur_idx;
   logic                    w_cur_valid;
   logic [RESP_W-1:0]       w_bank_data;
   logic                    w_bypass;
   logic                    w_in_hs;
   logic                    w_out_hs;
   logic                    w_store;
   logic                    w_release;

   // A slot competes for release when it holds a response whose ID is enabled;
   // it wins when no other competing slot is older than it.
   for (genvar i = 0; i < Capacity; i++) begin : g_cand
      assign w_cand[i] = valid_q[i] & release_en_i[data_q[i][RESP_W-1:1]];
      for (genvar j = 0; j < Capacity; j++) begin : g_col
         assign w_older_col[i][j] = older_q[j][i];
      end
      assign w_sel_oh[i] = w_cand[i] & ~|(w_cand & w_older_col[i]);
   end

   // Encode the winning slot and find the lowest free slot for the next write
   always_comb begin
      w_sel_idx = '0;
      w_wr_idx  = '0;
      for (int i = int'(Capacity) - 1; i >= 0; i--) begin
         if (w_sel_oh[i]) w_sel_idx = SlotIdxWidth'(i);
         if (!valid_q[i]) w_wr_idx  = SlotIdxWidth'(i);
      end
   end

   // A latched index keeps the presented response stable until it is taken
   assign w_cur_valid = locked_q | (|w_cand);
   assign w_cur_idx   = locked_q ? lock_idx_q : w_sel_idx;
   assign w_bank_data = w_cur_valid ? data_q[w_cur_idx] : '0;

`ifdef SIMMEM_WRITE_RESP_BANK_BYPASS_EN
   assign w_bypass    = (free_q == FREE_ALL) & in_valid_i & release_en_i[in_data_i[RESP_W-1:1]];
   assign out_valid_o = w_bypass | w_cur_valid;
   assign out_data_o  = w_bypass ? in_data_i : w_bank_data;
`else
   assign w_bypass    = 1'b0;
   assign out_valid_o = w_cur_valid;
   assign out_data_o  = w_bank_data;
`endif

   assign in_ready_o   = (free_q != '0);
   assign free_slots_o = free_q;
   assign w_in_hs      = in_valid_i & in_ready_o;
   assign w_out_hs     = out_valid_o & out_ready_i;
   // A bypassed response that is taken immediately never occupies a slot
   assign w_store      = w_in_hs & ~(w_bypass & out_ready_i);
   assign w_release    = w_out_hs & ~w_bypass;

   // Next-state for occupancy, free counter and output lock
   always_comb begin
      valid_d    = valid_q;
      free_d     = free_q;
      locked_d   = locked_q;
      lock_idx_d = lock_idx_q;
      if (w_release) valid_d[w_cur_idx] = 1'b0;
      if (w_store)   valid_d[w_wr_idx]  = 1'b1;
      case ({w_store, w_release})
         2'b10:   free_d = free_q - FREE_ONE;
         2'b01:   free_d = free_q + FREE_ONE;
         default: free_d = free_q;
      endcase
      if (w_out_hs) begin
         locked_d = 1'b0;
      end else if (out_valid_o && !locked_q) begin
         locked_d   = 1'b1;
         lock_idx_d = w_bypass ? w_wr_idx : w_cur_idx;
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q    <= '0;
         free_q     <= FREE_ALL;
         locked_q   <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         valid_q    <= valid_d;
         free_q     <= free_d;
         locked_q   <= locked_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   // Payload and age update: a new entry is younger than every slot valid now
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(Capacity); i++) begin
            data_q[i]  <= '0;
            older_q[i] <= '0;
         end
      end else if (w_store) begin
         data_q[w_wr_idx]  <= in_data_i;
         older_q[w_wr_idx] <= '0;
         for (int j = 0; j < int'(Capacity); j++) begin
            older_q[j][w_wr_idx] <= valid_q[j];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_simmem_write_resp_bank.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_simmem_write_resp_bank                                  |
// | Description : Self-checking bench with an arrival-ordered queue model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_simmem_write_resp_bank;

   localparam int CAP = 32;
`ifdef SIMMEM_WRITE_RESP_BANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [8:0]   in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [255:0] rel_en = '0;
   logic [8:0]   out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [5:0]   free_slots;

   always #5 clk = ~clk;

   simmem_write_resp_bank #(.Capacity(CAP), .SlotIdxWidth(5)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .in_data_i    (in_data),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .release_en_i (rel_en),
      .out_data_o   (out_data),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .free_slots_o (free_slots)
   );

   typedef struct {
      int         tag;
      logic [8:0] data;
   } ent_t;

   ent_t       mq[$];
   bit         m_locked = 1'b0;
   int         m_lock_tag = 0;
   int         next_tag = 0;
   int         checks = 0;
   int         failures = 0;
   bit         cap_on = 1'b0;
   logic [8:0] cap[$];

   function automatic logic [8:0] mk(input int id, input bit r);
      return {id[7:0], r};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected output: the locked entry, else the oldest queued entry whose ID
   // is enabled, else (bypass build) a qualifying input into an empty bank.
   function automatic void model_expect(output bit ev, output logic [8:0] ed,
                                        output bit byp, output int pos);
      ev = 1'b0; ed = '0; byp = 1'b0; pos = -1;
      if (m_locked) begin
         for (int i = 0; i < mq.size(); i++)
            if (mq[i].tag == m_lock_tag) pos = i;
         if (pos >= 0) begin
            ev = 1'b1;
            ed = mq[pos].data;
         end
      end else begin
         for (int i = 0; i < mq.size(); i++) begin
            if (rel_en[mq[i].data[8:1]]) begin
               pos = i;
               break;
            end
         end
         if (pos >= 0) begin
            ev = 1'b1;
            ed = mq[pos].data;
         end else if (BYP && mq.size() == 0 && in_valid && rel_en[in_data[8:1]]) begin
            byp = 1'b1;
            ev  = 1'b1;
            ed  = in_data;
         end
      end
   endfunction

   // Model state update on every clock edge, cleared by reset at once
   initial begin
      bit ev, byp, hs_in;
      logic [8:0] ed;
      int pos;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            m_locked = 1'b0;
         end else begin
            model_expect(ev, ed, byp, pos);
            hs_in = in_valid && (mq.size() < CAP);
            if (byp) begin
               if (!out_ready) begin
                  mq.push_back('{next_tag, in_data});
                  m_locked   = 1'b1;
                  m_lock_tag = next_tag;
                  next_tag++;
               end
            end else begin
               if (ev && out_ready) begin
                  mq.delete(pos);
                  m_locked = 1'b0;
               end else if (ev) begin
                  m_locked   = 1'b1;
                  m_lock_tag = mq[pos].tag;
               end
               if (hs_in) begin
                  mq.push_back('{next_tag, in_data});
                  next_tag++;
               end
            end
         end
      end
   end

   // Compare process: outputs against the model mid-cycle
   initial begin
      bit ev, byp;
      logic [8:0] ed;
      int pos;
      forever begin
         @(negedge clk);
         if (!rst) begin
            model_expect(ev, ed, byp, pos);
            check("out_valid", out_valid, ev);
            check("out_data", out_data, ed);
            check("in_ready", in_ready, mq.size() < CAP);
            check("free_slots", free_slots, CAP - mq.size());
            if (cap_on && out_valid && out_ready) cap.push_back(out_data);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] exp_seq [3];
      // Reset state
      step();
      #1;
      check("rst_free", free_slots, 32);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      step();
      rst = 1'b0;

      // Same-ID ordering
      rel_en = '0; rel_en[3] = 1'b1; out_ready = 1'b1;
      in_valid = 1'b1; in_data = mk(3, 1'b0); cap_on = 1'b1;
      #1;
      check("t1_first_latency", out_valid, BYP);
      step(); in_data = mk(3, 1'b1);
      step(); in_data = mk(3, 1'b0);
      step(); in_valid = 1'b0;
      repeat (4) step();
      cap_on = 1'b0;
      exp_seq[0] = 9'h006; exp_seq[1] = 9'h007; exp_seq[2] = 9'h006;
      check("t1_count", cap.size(), 3);
      for (int i = 0; i < 3; i++)
         check("t1_order", (cap.size() > i) ? cap[i] : 9'h1ff, exp_seq[i]);
      #1;
      check("t1_free_end", free_slots, 32);

      // Fill to capacity
      rel_en = '0; out_ready = 1'b0;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1; in_data = mk(i, i[0]);
         step();
      end
      in_valid = 1'b0;
      #1;
      check("t2_full_free", free_slots, 0);
      check("t2_full_ready", in_ready, 0);
      in_valid = 1'b1; in_data = mk(99, 1'b0);
      step();
      in_valid = 1'b0;
      #1;
      check("t2_33rd_ignored", free_slots, 0);
      rel_en[0] = 1'b1; out_ready = 1'b1;
      #1;
      check("t2_slot0_valid", out_valid, 1);
      check("t2_slot0_data", out_data, mk(0, 1'b0));
      step();
      out_ready = 1'b0; rel_en = '0;
      #1;
      check("t2_ready_after", in_ready, 1);
      check("t2_free_after", free_slots, 1);
      rel_en = '1; out_ready = 1'b1;
      repeat (40) step();
      check("t2_drained", free_slots, 32);
      rel_en = '0; out_ready = 1'b0;

      // Different IDs released out of order
      in_valid = 1'b1; in_data = mk(5, 1'b0);
      step(); in_data = mk(9, 1'b1);
      step(); in_valid = 1'b0;
      rel_en[9] = 1'b1; out_ready = 1'b1;
      #1;
      check("t3_id9_first", out_data, mk(9, 1'b1));
      step();
      rel_en = '0; rel_en[5] = 1'b1;
      #1;
      check("t3_id5_next", out_data, mk(5, 1'b0));
      step();
      rel_en = '0; out_ready = 1'b0;
      #1;
      check("t3_free_end", free_slots, 32);

      // Lock holds the presented response
      rel_en[7] = 1'b1; in_valid = 1'b1; in_data = mk(7, 1'b0);
      step();
      in_valid = 1'b0;
      #1;
      check("t4_id7_shown", out_data, mk(7, 1'b0));
      step();
      rel_en = '0; rel_en[2] = 1'b1; in_valid = 1'b1; in_data = mk(2, 1'b1);
      #1;
      check("t4_hold_en_drop", out_data, mk(7, 1'b0));
      step();
      in_valid = 1'b0;
      #1;
      check("t4_hold_new_entry", out_data, mk(7, 1'b0));
      out_ready = 1'b1;
      step();
      #1;
      check("t4_id2_follows", out_data, mk(2, 1'b1));
      step();
      out_ready = 1'b0; rel_en = '0;
      #1;
      check("t4_free_end", free_slots, 32);

      // Asynchronous reset with stored entries and a held lock
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = mk(10 + i, 1'b0);
         step();
      end
      in_valid = 1'b0; rel_en[10] = 1'b1;
      step();
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_free", free_slots, 32);
      check("t5_rst_ready", in_ready, 1);
      step(); step();
      rst = 1'b0; rel_en = '1; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t5_no_stale", out_valid, 0);
         step();
      end
      rel_en = '0; out_ready = 1'b0;

      // Bypass / minimum latency
      rel_en[4] = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = mk(4, 1'b0);
      #1;
      check("t6_same_cycle_valid", out_valid, BYP);
      check("t6_same_cycle_data", out_data, BYP ? mk(4, 1'b0) : 9'h000);
      step();
      in_valid = 1'b0;
      #1;
      check("t6_next_valid", out_valid, !BYP);
      check("t6_next_free", free_slots, BYP ? 32 : 31);
      step();
      #1;
      check("t6_free_end", free_slots, 32);
      rel_en = '0; out_ready = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int vp, rp, id;
         vp = ((n / 500) % 2 == 1) ? 90 : 55;
         rp = ((n / 500) % 2 == 1) ? 20 : 55;
         in_valid = ($urandom_range(0, 99) < vp);
         id = $urandom_range(0, 9);
         if (id == 8) id = 200;
         if (id == 9) id = 255;
         in_data = mk(id, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 99) < 30) begin
            rel_en[7:0] = 8'($urandom);
            rel_en[200] = $urandom_range(0, 1) == 1;
            rel_en[255] = $urandom_range(0, 1) == 1;
         end
         out_ready = ($urandom_range(0, 99) < rp);
         step();
      end
      in_valid = 1'b0; rel_en = '1; out_ready = 1'b1;
      repeat (40) step();
      check("rand_drained", free_slots, 32);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/simmem_write_resp_bank.md
# simmem_write_resp_bank

Response-holding stage directly downstream of the real memory's AXI B channel in the simulated-memory design. Accepts `write_resp_t` responses from the memory side, stores up to `WriteRespBankTotalCapacity` of them, and releases them to the requester only when the delay logic enables the response's AXI ID. Responses sharing an ID always leave in arrival order. Responses with different IDs may leave in any order the release mask permits.

## Interface
Parameters:
- `Capacity`, default `WriteRespBankTotalCapacity` (32): number of storage slots.
- `SlotIdxWidth`, default `WriteRespBankAddrWidth` (5): width of a slot index. Equals `$clog2(Capacity)`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `in_data_i`  in  `WriteRespWidth` (9)  response from memory, type `write_resp_t`.
- `in_valid_i`  in  1  input handshake valid.
- `in_ready_o`  out  1  input handshake ready; high when at least one slot is free.
- `release_en_i`  in  `NumIds` (256)  bit k set: stored responses with id k may be released.
- `out_data_o`  out  `WriteRespWidth`  response to requester.
- `out_valid_o`  out  1  output handshake valid.
- `out_ready_i`  in  1  output handshake ready.
- `free_slots_o`  out  `SlotIdxWidth+1`  number of currently free slots, 0..Capacity.

## Operation
- Each slot holds a `valid` bit and a 9-bit response. Relative arrival order is tracked by an age matrix: `older[i][j]` is set when slot i was written before slot j.
- **Write.** An input handshake (`in_valid_i && in_ready_o`) stores `in_data_i` in the lowest-index free slot. The slot's row is set to 0 and its column is set to 1 for all currently valid slots.
- **Candidates.** A slot is a candidate when it is valid and `release_en_i[slot.id]` is set.
- **Selection.** The selected slot is the candidate that no other candidate is older than. This is always the oldest enabled response, so per-ID order holds.
- **Lock.** When `out_valid_o` is high and `out_ready_i` is low, the selected slot index is latched (`locked`).
  - While locked, `out_data_o` and `out_valid_o` stay fixed, even if `release_en_i` changes or newer entries arrive.
  - The lock clears on the output handshake.
- **Release.** An output handshake (`out_valid_o && out_ready_i`) clears the slot's valid bit.
- **`free_slots_o`** is a registered counter. It changes by +1 on a release only, -1 on a write only, and 0 when both occur in the same cycle.
- **`in_ready_o`** equals `free_slots_o != 0`. It does not depend on `out_ready_i`: a slot freed in cycle N can be rewritten from cycle N+1.

## Timing
- Reset values: all slots invalid, age matrix cleared, `locked` = 0, `free_slots_o` = Capacity, `in_ready_o` = 1, `out_valid_o` = 0, `out_data_o` = 0.
- Latency: a response written at edge N can appear on `out_valid_o` in cycle N+1 at the earliest (without `SIMMEM_WRITE_RESP_BANK_BYPASS_EN`).
- `out_valid_o` and `out_data_o` are combinational from the registered slot state and `release_en_i`, except while locked, when they come from the latched index.
- Full: when `free_slots_o` = 0, `in_ready_o` = 0 and input is ignored. A release in that cycle raises `in_ready_o` in the next cycle.
- Empty, or no candidate: `out_valid_o` = 0 and `out_data_o` = 0.
- Simultaneous write and release in one cycle: both take effect. The new entry never takes the slot being released in that same cycle.
- Reset asserted mid-operation: all stored responses are discarded immediately (asynchronously), including a locked one.

## Configuration
- Macro: `SIMMEM_WRITE_RESP_BANK_BYPASS_EN`.
- Defined:
  - When the bank is empty, `in_valid_i` = 1 and `release_en_i[in_data_i.id]` = 1, the input goes combinationally to the output (`out_data_o = in_data_i`, `out_valid_o` = 1).
  - If `out_ready_i` = 1, nothing is stored and `free_slots_o` is unchanged.
  - If `out_ready_i` = 0, the entry is stored normally and locked.
- Undefined: no bypass. The minimum latency is 1 cycle.

## Test plan
- Reset, then write ids 3, 3, 3 with responses 0, 1, 0, with `release_en_i[3]` = 1 and `out_ready_i` = 1 → output order is resp 0, 1, 0 with id 3, one per cycle starting at cycle N+1. `free_slots_o` ends at 32.
- Write 32 responses with `release_en_i` = 0 → `in_ready_o` = 0 and `free_slots_o` = 0. A 33rd valid input is not accepted. Enable id of slot 0 and pulse `out_ready_i` → `in_ready_o` = 1 on the next cycle.
- Write id 5 then id 9, and enable only bit 9 → id 9 released first. Then enable bit 5 → id 5 released.
- Valid output for id 7 with `out_ready_i` = 0, then drop `release_en_i[7]` and write an older-enabled id 2 → output stays id 7 until the handshake, then id 2 follows.
- Assert `rst_i` with 10 entries stored and a lock held → `out_valid_o` = 0 and `free_slots_o` = 32 immediately, with no stale entry after reset deasserts.
- With the bypass macro, empty bank, id 4 enabled and `out_ready_i` = 1 → same-cycle output, `free_slots_o` stays 32. Without the macro → output appears one cycle later.
